// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared pipeline definitions: control-word layout used by the ID decoder,
// this ID/EX register and the EX decoder.
package id_ex_pipe_reg_pkg;

  localparam int unsigned CtrlW    = 12;
  localparam int unsigned RegAddrW = 5;

  // Control-word bit positions
  localparam int unsigned CtrlRegWrite   = 11;
  localparam int unsigned CtrlAluOpHi    = 10;
  localparam int unsigned CtrlAluOpLo    = 8;
  localparam int unsigned CtrlAluSrc     = 7;
  localparam int unsigned CtrlRegDst     = 6;
  localparam int unsigned CtrlBranch     = 5;
  localparam int unsigned CtrlJump       = 4;
  localparam int unsigned CtrlMemRead    = 3;
  localparam int unsigned CtrlMemWrite   = 2;
  localparam int unsigned CtrlMemtoReg   = 1;
  localparam int unsigned CtrlBranchType = 0;

  // An invalid slot must carry no side effects into EX.
  function automatic logic [CtrlW-1:0] gateCtrl(input logic [CtrlW-1:0] ctrl,
                                                input logic            valid);
    return valid ? ctrl : '0;
  endfunction

endpackage

// File: rtl/pipe_field_reg.sv
// Parameterised pipeline field register: sync reset, sync clear, hold, load.
module pipe_field_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             hold_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] dataQ;

  // Clear outranks hold so a flush during a stall still inserts a bubble.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      dataQ <= '0;
    end else if (!hold_i) begin
      dataQ <= d_i;
    end
  end

  assign q_o = dataQ;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall, flush-to-bubble and a saturating count
// of flush-inserted bubbles.
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic                valid_i,
  input  logic [CtrlW-1:0]    ctrl_i,
  input  logic [DATA_W-1:0]   pc_plus4_i,
  input  logic [DATA_W-1:0]   rs_data_i,
  input  logic [DATA_W-1:0]   rt_data_i,
  input  logic [DATA_W-1:0]   imm_i,
  input  logic [RegAddrW-1:0] rs_addr_i,
  input  logic [RegAddrW-1:0] rt_addr_i,
  input  logic [RegAddrW-1:0] rd_addr_i,
  output logic [CtrlW-1:0]    ctrl_o,
  output logic [DATA_W-1:0]   pc_plus4_o,
  output logic [DATA_W-1:0]   rs_data_o,
  output logic [DATA_W-1:0]   rt_data_o,
  output logic [DATA_W-1:0]   imm_o,
  output logic [RegAddrW-1:0] rs_addr_o,
  output logic [RegAddrW-1:0] rt_addr_o,
  output logic [RegAddrW-1:0] rd_addr_o,
  output logic                valid_o,
  output logic [CNT_W-1:0]    bubble_cnt_o
);

  localparam int unsigned DataGrpW = 4 * DATA_W;
  localparam int unsigned AddrGrpW = 3 * RegAddrW;

  logic [CtrlW-1:0]    ctrlD;
  logic [DataGrpW-1:0] dataD, dataQ;
  logic [AddrGrpW-1:0] addrD, addrQ;
  logic [CNT_W-1:0]    bubbleCntQ;

  assign ctrlD = gateCtrl(ctrl_i, valid_i);
  assign dataD = {pc_plus4_i, rs_data_i, rt_data_i, imm_i};
  assign addrD = {rs_addr_i, rt_addr_i, rd_addr_i};

  pipe_field_reg #(.Width(CtrlW)) uCtrlReg (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (flush_i),
    .hold_i (stall_i),
    .d_i    (ctrlD),
    .q_o    (ctrl_o)
  );

  pipe_field_reg #(.Width(1)) uValidReg (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (flush_i),
    .hold_i (stall_i),
    .d_i    (valid_i),
    .q_o    (valid_o)
  );

  pipe_field_reg #(.Width(DataGrpW)) uDataReg (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (flush_i),
    .hold_i (stall_i),
    .d_i    (dataD),
    .q_o    (dataQ)
  );

  pipe_field_reg #(.Width(AddrGrpW)) uAddrReg (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (flush_i),
    .hold_i (stall_i),
    .d_i    (addrD),
    .q_o    (addrQ)
  );

  assign {pc_plus4_o, rs_data_o, rt_data_o, imm_o} = dataQ;
  assign {rs_addr_o, rt_addr_o, rd_addr_o}         = addrQ;

  // Saturates at all-ones so a long flush storm never reads as zero bubbles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bubbleCntQ <= '0;
    end else if (flush_i && (bubbleCntQ != '1)) begin
      bubbleCntQ <= bubbleCntQ + CNT_W'(1);
    end
  end

  assign bubble_cnt_o = bubbleCntQ;

endmodule

// File: doc/id_ex_pipe_reg.md
ID_EX_PIPE_REG -- requirements
Module: id_ex_pipe_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of PC+4, register-data and immediate fields.
REQ-002 SHALL have parameter CNT_W, default 16: width of bubble counter.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port stall_i  input  1  hold current contents (load-use hazard).
REQ-006 SHALL have port flush_i  input  1  replace the captured stage with a bubble.
REQ-007 SHALL have port valid_i  input  1  ID stage holds a real instruction.
REQ-008 SHALL have port ctrl_i  input  12  packed control: RegWrite, ALUOp[2:0], ALUSrc, RegDst, Branch, Jump, MemRead, MemWrite, MemtoReg, BranchType.
REQ-009 SHALL have ports pc_plus4_i, rs_data_i, rt_data_i, imm_i  input  DATA_W each  ID-stage data.
REQ-010 SHALL have ports rs_addr_i, rt_addr_i, rd_addr_i  input  5 each  register specifiers.
REQ-011 SHALL have output ports ctrl_o, pc_plus4_o, rs_data_o, rt_data_o, imm_o, rs_addr_o, rt_addr_o, rd_addr_o, each with the width of its matching input and all registered.
REQ-012 SHALL have port valid_o  output  1  EX stage holds a real instruction.
REQ-013 SHALL have port bubble_cnt_o  output  CNT_W  count of flush-inserted bubbles.

Function
REQ-014 SHALL apply per-edge priority: rst_i > flush_i > stall_i > load.
REQ-015 SHALL, on load, capture every input to its output, for a latency of exactly one cycle.
REQ-016 SHALL, on load with valid_i=0, force ctrl_o=0, valid_o=0, and still capture the data fields.
REQ-017 SHALL, on flush, set ctrl_o=0, valid_o=0 and all data/address outputs to 0.
REQ-018 SHALL, on stall without flush, hold all outputs and the counter unchanged.
REQ-019 SHALL make flush_i and stall_i asserted together behave as flush.
REQ-020 SHALL increment bubble_cnt_o by 1 on each flush edge, saturating at all-ones with no wrap.
REQ-021 SHALL ensure a stalled register never drops or duplicates the held instruction: after the stall releases, the held instruction remains in EX for exactly one further load cycle.
REQ-022 SHALL be fully registered, with no combinational path from any input to any output.

Reset
REQ-023 SHALL, on rst_i=1 at a clock edge, clear all outputs to 0, including valid_o and bubble_cnt_o.
REQ-024 SHALL let rst_i asserted mid-stall or mid-flush override both.
REQ-025 SHALL resume loading on the first edge after rst_i deasserts.

Structure
REQ-026 SHALL take the ctrl bit positions (RegWrite=11, ALUOp=10:8, ALUSrc=7, RegDst=6, Branch=5, Jump=4, MemRead=3, MemWrite=2, MemtoReg=1, BranchType=0) and the width 12 as localparams from a shared pipeline package/include, which the ID and EX decoders also use.
REQ-027 SHALL contain one sub-module, pipe_field_reg: a parameterised-width register with sync clear, clear, hold and load controls, instantiated per field group.
REQ-028 SHALL keep the saturating counter in the top level.

Verification
REQ-029 SHALL verify load: valid_i=1, ctrl_i=12'h8A5, rs_data_i=32'h1234_5678 -> next edge ctrl_o=12'h8A5, rs_data_o=32'h1234_5678, valid_o=1.
REQ-030 SHALL verify stall: stall_i=1 for 3 edges while inputs change to 32'hDEAD_BEEF -> outputs keep the prior values; on release they load the new values one edge later.
REQ-031 SHALL verify flush priority: flush_i=1 and stall_i=1 with ctrl_i=12'hFFF -> ctrl_o=0, valid_o=0, all data outputs 0, bubble_cnt_o +1.
REQ-032 SHALL verify saturation: preload via 65535 flush edges and apply one more flush -> bubble_cnt_o stays 16'hFFFF.
REQ-033 SHALL verify reset mid-operation: counter=5 and valid_o=1, then rst_i=1 for one edge together with flush_i=1 -> all outputs 0, counter 0.
REQ-034 SHALL verify invalid load: valid_i=0 with ctrl_i=12'hFFF and imm_i=32'h0000_0010 -> ctrl_o=0, valid_o=0, imm_o=32'h0000_0010.
